sync_fifo_ext: RTL
==================

Name: sync_fifo_ext

Overview:
Parametrised synchronous single-clock FIFO. It is the next-generation replacement for the basic 16x8 FIFO in the IP library. Depth and width are generic. Adds:
- selectable read mode: first-word-fall-through or registered read
- occupancy count output
- almost-full / almost-empty thresholds
- synchronous flush
- overflow / underflow error pulses
- simultaneous push+pop accepted when full

Used as the general buffering primitive between streaming blocks.

Parameters:
WIDTH_DATA, 8, data word width in bits (>=1)
ADDR_WIDTH, 4, pointer width; DEPTH = 2**ADDR_WIDTH words (ADDR_WIDTH >= 1)
AFULL_THR, DEPTH-2, o_almost_full asserted when count >= AFULL_THR (1..DEPTH)
AEMPTY_THR, 2, o_almost_empty asserted when count <= AEMPTY_THR (0..DEPTH-1)
FWFT, 1, 1 = show-ahead combinational read data; 0 = registered read data, 1-cycle latency

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_flush  input  1  synchronous clear of FIFO contents
i_data_in  input  WIDTH_DATA  write data
i_push  input  1  write request
i_pop  input  1  read request
o_data_out  output  WIDTH_DATA  read data
o_valid  output  1  o_data_out holds valid data
o_count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
o_empty  output  1  count == 0
o_full  output  1  count == DEPTH
o_almost_empty  output  1  count <= AEMPTY_THR
o_almost_full  output  1  count >= AFULL_THR
o_overflow  output  1  1-cycle pulse: push rejected
o_underflow  output  1  1-cycle pulse: pop rejected

Behaviour:
- Reset, asynchronous and active-low, applies to wr_ptr, rd_ptr, count, o_overflow, o_underflow and the registered o_data_out/o_valid (FWFT=0) — all forced to 0. Flags follow count: o_empty=1, o_almost_empty=1, o_full=0, o_almost_full=0. Memory array is not reset.
- Reset mid-operation: all stored words are discarded. The first push after reset lands at address 0.
- Status flags and o_count are combinational from the count register. They reflect the state after the last clock edge.
- pop_ok = i_pop & !o_empty.
- push_ok = i_push & (!o_full | pop_ok).
  - When full, push+pop in the same cycle are both accepted and count is unchanged.
  - When empty, push+pop in the same cycle: push accepted, pop rejected, o_underflow pulses, count becomes 1.
- Rejected push (i_push & !push_ok): o_overflow=1 next cycle for one cycle. Memory and pointers are unchanged.
- Rejected pop (i_pop & !pop_ok): o_underflow=1 next cycle for one cycle.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Pointers are ADDR_WIDTH bits and advance by 1 on the accepted operation, wrapping DEPTH-1 -> 0 naturally.
- Write: on push_ok, mem[wr_ptr] <= i_data_in at the clock edge.
- FWFT=1 read mode:
  - o_valid = !o_empty.
  - o_data_out = mem[rd_ptr] when !o_empty, else all zeros.
  - A word pushed at edge N is visible on o_data_out after edge N (zero-cycle fall-through).
- FWFT=0 read mode:
  - On pop_ok, o_data_out <= mem[rd_ptr] and o_valid <= 1.
  - Otherwise o_valid <= 0 and o_data_out holds its last value.
  - Read latency is 1 cycle from the accepted pop.
- i_flush has the highest priority after reset. At the edge it clears wr_ptr, rd_ptr and count.
  - Push and pop in the same cycle are ignored and raise no error pulses.
  - FWFT=0: o_valid <= 0; o_data_out is held.
  - Memory contents are not cleared.
- Threshold flags are independent of full/empty and may overlap (e.g. DEPTH=2).
- Width rule: count is ADDR_WIDTH+1 bits so DEPTH is representable; no other arithmetic overflow is possible.
- No combinational path from i_push or i_pop to any output.

Test Plan:
- Defaults (W=8, DEPTH=16, FWFT=1): reset, push 0x01..0x10 on 16 cycles -> o_count steps 1..16; o_almost_full asserts at count 14; o_full=1 at 16; o_data_out=0x01 throughout.
- Full FIFO, push 0xAA alone -> o_overflow pulses 1 cycle, count stays 16. Then push 0xBB + pop together -> count 16, o_data_out 0x02, 0xBB stored at the wrapped address 0.
- Drain all 16 words with continuous pop -> data sequence 0x02..0x10, 0xBB in order; o_almost_empty at count 2; o_empty after the last pop. One extra pop -> o_underflow pulse, o_data_out=0.
- Empty FIFO, push 0x55 + pop same cycle -> o_underflow pulses, count=1, o_data_out=0x55 next cycle.
- FWFT=0: push 0x11, 0x22, then pop on cycle N -> o_valid=1 and o_data_out=0x11 at N+1; no pop at N+1 -> o_valid=0 at N+2 with data held at 0x11.
- Count=5, assert i_flush with push+pop -> next cycle count=0, o_empty=1, no error pulses. Assert i_rst_n=0 mid-burst -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sync_fifo_ext_if.sv
// Handshake and status bundle for sync_fifo_ext. The producer/consumer side uses
// the master modport, and the FIFO uses the slave modport.
interface sync_fifo_ext_if #(
   parameter int WIDTH_DATA = 8,
   parameter int ADDR_WIDTH = 4
);
   logic                  i_flush;
   logic [WIDTH_DATA-1:0] i_data_in;
   logic                  i_push;
   logic                  i_pop;
   logic [WIDTH_DATA-1:0] o_data_out;
   logic                  o_valid;
   logic [ADDR_WIDTH:0]   o_count;
   logic                  o_empty;
   logic                  o_full;
   logic                  o_almost_empty;
   logic                  o_almost_full;
   logic                  o_overflow;
   logic                  o_underflow;

   modport master (
      output i_flush, i_data_in, i_push, i_pop,
      input  o_data_out, o_valid, o_count, o_empty, o_full,
             o_almost_empty, o_almost_full, o_overflow, o_underflow
   );

   modport slave (
      input  i_flush, i_data_in, i_push, i_pop,
      output o_data_out, o_valid, o_count, o_empty, o_full,
             o_almost_empty, o_almost_full, o_overflow, o_underflow
   );
endinterface

// File: rtl/sync_fifo_ext.sv
// Parametrised single-clock FIFO with selectable show-ahead or registered read, occupancy
// and threshold flags, synchronous flush, and overflow/underflow error pulses.
module sync_fifo_ext #(
   parameter int WIDTH_DATA = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int AFULL_THR  = (2 ** ADDR_WIDTH) - 2,
   parameter int AEMPTY_THR = 2,
   parameter int FWFT       = 1
) (
   input logic           i_clk,
   input logic           i_rst_n,
   sync_fifo_ext_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] FULL_CNT   = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AFULL_CNT  = (ADDR_WIDTH + 1)'(AFULL_THR);
   localparam logic [ADDR_WIDTH:0] AEMPTY_CNT = (ADDR_WIDTH + 1)'(AEMPTY_THR);

   logic [WIDTH_DATA-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   count;
   logic                  overflow;
   logic                  underflow;
   logic                  empty;
   logic                  full;
   logic                  push_ok;
   logic                  pop_ok;
   logic [WIDTH_DATA-1:0] rd_data;
   logic                  rd_valid;

   assign empty = (count == '0);
   assign full  = (count == FULL_CNT);

   // A pop frees a slot in the same cycle, so a full FIFO still accepts push+pop together.
   assign pop_ok  = bus.i_pop & ~empty;
   assign push_ok = bus.i_push & (~full | pop_ok);

   // Pointer, occupancy and error-pulse state; flush clears it all without raising errors.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (bus.i_flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         overflow  <= bus.i_push & ~push_ok;
         underflow <= bus.i_pop & ~pop_ok;
      end
   end

   // Storage is deliberately left unreset; only accepted pushes outside flush and reset write it.
   always_ff @(posedge i_clk) begin
      if (i_rst_n && !bus.i_flush && push_ok) mem[wr_ptr] <= bus.i_data_in;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign rd_valid = ~empty;
         assign rd_data  = empty ? '0 : mem[rd_ptr];
      end else begin : g_registered
         logic [WIDTH_DATA-1:0] data_q;
         logic                  valid_q;

         // Registered read port: data is captured on an accepted pop and held otherwise.
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               data_q  <= '0;
               valid_q <= 1'b0;
            end else if (bus.i_flush) begin
               valid_q <= 1'b0;
            end else if (pop_ok) begin
               data_q  <= mem[rd_ptr];
               valid_q <= 1'b1;
            end else begin
               valid_q <= 1'b0;
            end
         end

         assign rd_valid = valid_q;
         assign rd_data  = data_q;
      end
   endgenerate

   assign bus.o_data_out     = rd_data;
   assign bus.o_valid        = rd_valid;
   assign bus.o_count        = count;
   assign bus.o_empty        = empty;
   assign bus.o_full         = full;
   assign bus.o_almost_empty = (count <= AEMPTY_CNT);
   assign bus.o_almost_full  = (count >= AFULL_CNT);
   assign bus.o_overflow     = overflow;
   assign bus.o_underflow    = underflow;
endmodule
